arm7_dp_alu: RTL and testbench

Multi-cycle ARM7 data-processing executor. Accepts one decoded data-processing instruction, fetches mode, Rn, Rm and CPSR from the register file over its shared single read port, computes the result, then writes Rd and/or CPSR flags. Sits between the instruction decoder and register_file; it owns no architectural state.

---
 rtl/arm7_pkg.sv | 50 +++++
 rtl/arm7_dp_alu_if.sv | 42 ++++
 rtl/arm7_dp_compute.sv | 56 +++++
 rtl/arm7_dp_alu.sv | 132 +++++++++++++
 tb/tb_arm7_dp_alu.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/arm7_pkg.sv
// Shared ARM7 constants for the data-processing executor: opcodes, CPSR flag
// positions, privileged-mode encodings and the executor's FSM state type.
package arm7_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MODE_RD,
        S_MODE_CAP,
        S_OP1_RD,
        S_OP1_CAP,
        S_OP2_RD,
        S_OP2_CAP,
        S_CPSR_RD,
        S_CPSR_CAP,
        S_EXEC,
        S_WRITE,
        S_FLAGS
    } state_t;

    // TST/TEQ/CMP/CMN occupy opcodes 8..B and never write Rd.
    function automatic logic is_test_op(input logic [3:0] opc);
        return opc[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/arm7_dp_alu_if.sv
// Decoder-side command and register-file-side access signals of the executor.
interface arm7_dp_alu_if;

    logic        en;
    logic        immediate;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] operand2;

    logic        write_en;
    logic [3:0]  write_reg;
    logic [31:0] write_value;
    logic        write_restore_from_SPSR;
    logic        read_en;
    logic [3:0]  read_reg;
    logic [31:0] read_value;
    logic        mode_read_en;
    logic [31:0] mode_read_value;
    logic        cpsr_read_en;
    logic [31:0] cpsr_read_value;
    logic        cpsr_write_en;
    logic [31:0] cpsr_write_value;

    modport master (
        input  en, immediate, opcode, s, rn, rd, operand2,
        input  read_value, mode_read_value, cpsr_read_value,
        output write_en, write_reg, write_value, write_restore_from_SPSR,
        output read_en, read_reg, mode_read_en, cpsr_read_en,
        output cpsr_write_en, cpsr_write_value
    );

    modport slave (
        output en, immediate, opcode, s, rn, rd, operand2,
        output read_value, mode_read_value, cpsr_read_value,
        input  write_en, write_reg, write_value, write_restore_from_SPSR,
        input  read_en, read_reg, mode_read_en, cpsr_read_en,
        input  cpsr_write_en, cpsr_write_value
    );

endinterface

// File: rtl/arm7_dp_compute.sv
// Combinational ARM7 data-processing result and NZCV computation.
module arm7_dp_compute
    import arm7_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        cin,
    input  logic        vin,
    output logic [31:0] result,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v,
    output logic        writes_rd
);

    logic [31:0] x;
    logic [31:0] y;
    logic        ci;
    logic        arith;
    logic [31:0] logic_res;
    logic [32:0] sum;

    // Every arithmetic op is x + y + ci; subtraction feeds the inverted operand.
    always_comb begin
        x         = op1;
        y         = op2;
        ci        = 1'b0;
        arith     = 1'b1;
        logic_res = '0;
        case (opcode)
            OP_AND, OP_TST: begin arith = 1'b0; logic_res = op1 & op2; end
            OP_EOR, OP_TEQ: begin arith = 1'b0; logic_res = op1 ^ op2; end
            OP_SUB, OP_CMP: begin y = ~op2; ci = 1'b1; end
            OP_RSB:         begin x = op2; y = ~op1; ci = 1'b1; end
            OP_ADD, OP_CMN: begin end
            OP_ADC:         begin ci = cin; end
            OP_SBC:         begin y = ~op2; ci = cin; end
            OP_RSC:         begin x = op2; y = ~op1; ci = cin; end
            OP_ORR:         begin arith = 1'b0; logic_res = op1 | op2; end
            OP_MOV:         begin arith = 1'b0; logic_res = op2; end
            OP_BIC:         begin arith = 1'b0; logic_res = op1 & ~op2; end
            default:        begin arith = 1'b0; logic_res = ~op2; end
        endcase
    end

    assign sum       = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    assign result    = arith ? sum[31:0] : logic_res;
    assign c         = arith ? sum[32] : cin;
    assign v         = arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : vin;
    assign n         = result[31];
    assign z         = (result == 32'd0);
    assign writes_rd = !is_test_op(opcode);

endmodule

// File: rtl/arm7_dp_alu.sv
// Multi-cycle ARM7 data-processing executor: reads mode, Rn, Rm and CPSR over
// the shared register-file port, then writes Rd and/or the CPSR flags.
module arm7_dp_alu
    import arm7_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    arm7_dp_alu_if.master bus
);

    state_t      state, state_nxt;

    logic        imm_q;
    logic [3:0]  opc_q;
    logic        s_q;
    logic [3:0]  rn_q;
    logic [3:0]  rd_q;
    logic [11:0] op2f_q;
    logic [4:0]  mode_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] cpsr_q;
    logic [31:0] result_q;
    logic [31:0] cpsr_new_q;
    logic        restore_q;
    logic        flags_q;

    logic [31:0] res;
    logic        n, z, c, v, writes_rd;
    logic        restore, do_flags;
    logic        unused;

    arm7_dp_compute u_compute (
        .opcode    (opc_q),
        .op1       (op1_q),
        .op2       (op2_q),
        .cin       (cpsr_q[CPSR_C]),
        .vin       (cpsr_q[CPSR_V]),
        .result    (res),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v),
        .writes_rd (writes_rd)
    );

    // In privileged modes, S with Rd=r15 returns from exception via SPSR instead of setting flags.
    assign restore  = (rd_q == 4'd15) && s_q && !is_test_op(opc_q)
                      && (mode_q != MODE_USR) && (mode_q != MODE_SYS);
    assign do_flags = (s_q || is_test_op(opc_q)) && !restore;
    assign unused   = ^{bus.mode_read_value[31:5]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        bus.read_en       = 1'b0;
        bus.read_reg      = 4'd0;
        bus.mode_read_en  = 1'b0;
        bus.cpsr_read_en  = 1'b0;
        bus.write_en      = 1'b0;
        bus.cpsr_write_en = 1'b0;
        case (state)
            S_IDLE:     if (bus.en) state_nxt = S_MODE_RD;
            S_MODE_RD:  begin bus.mode_read_en = 1'b1; state_nxt = S_MODE_CAP; end
            S_MODE_CAP: state_nxt = S_OP1_RD;
            S_OP1_RD:   begin bus.read_en = 1'b1; bus.read_reg = rn_q; state_nxt = S_OP1_CAP; end
            S_OP1_CAP:  state_nxt = imm_q ? S_CPSR_RD : S_OP2_RD;
            S_OP2_RD:   begin bus.read_en = 1'b1; bus.read_reg = op2f_q[3:0]; state_nxt = S_OP2_CAP; end
            S_OP2_CAP:  state_nxt = S_CPSR_RD;
            S_CPSR_RD:  begin bus.cpsr_read_en = 1'b1; state_nxt = S_CPSR_CAP; end
            S_CPSR_CAP: state_nxt = S_EXEC;
            S_EXEC:     state_nxt = writes_rd ? S_WRITE : (do_flags ? S_FLAGS : S_IDLE);
            S_WRITE:    begin bus.write_en = 1'b1; state_nxt = flags_q ? S_FLAGS : S_IDLE; end
            S_FLAGS:    begin bus.cpsr_write_en = 1'b1; state_nxt = S_IDLE; end
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_q      <= 1'b0;
            opc_q      <= 4'd0;
            s_q        <= 1'b0;
            rn_q       <= 4'd0;
            rd_q       <= 4'd0;
            op2f_q     <= 12'd0;
            mode_q     <= 5'd0;
            op1_q      <= 32'd0;
            op2_q      <= 32'd0;
            cpsr_q     <= 32'd0;
            result_q   <= 32'd0;
            cpsr_new_q <= 32'd0;
            restore_q  <= 1'b0;
            flags_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.en) begin
                    imm_q  <= bus.immediate;
                    opc_q  <= bus.opcode;
                    s_q    <= bus.s;
                    rn_q   <= bus.rn;
                    rd_q   <= bus.rd;
                    op2f_q <= bus.operand2;
                end
                S_MODE_CAP: mode_q <= bus.mode_read_value[4:0];
                S_OP1_CAP: begin
                    op1_q <= bus.read_value;
                    if (imm_q) op2_q <= {20'd0, op2f_q};
                end
                S_OP2_CAP:  op2_q  <= bus.read_value;
                S_CPSR_CAP: cpsr_q <= bus.cpsr_read_value;
                S_EXEC: begin
                    result_q   <= res;
                    cpsr_new_q <= {n, z, c, v, cpsr_q[27:0]};
                    restore_q  <= restore;
                    flags_q    <= do_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.write_reg               = rd_q;
    assign bus.write_value             = result_q;
    assign bus.write_restore_from_SPSR = bus.write_en & restore_q;
    assign bus.cpsr_write_value        = cpsr_new_q;

endmodule

// File: tb/tb_arm7_dp_alu.sv
// Bench for arm7_dp_alu: register-file model plus a scoreboard of expected
// Rd and CPSR writes, compared as the executor issues them.
module tb_arm7_dp_alu;

    typedef struct packed {
        logic        is_cpsr;
        logic [3:0]  rg;
        logic [31:0] val;
        logic        rest;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] regs [16];
    logic [4:0]  mode;
    logic [31:0] cpsr;
    exp_t        sb [$];
    int          n_vec;
    int          n_err;
    int          onehot_viol;

    arm7_dp_alu_if bus ();

    arm7_dp_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Register-file model: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.read_en)      bus.read_value      <= regs[bus.read_reg];
        if (bus.mode_read_en) bus.mode_read_value <= {27'd0, mode};
        if (bus.cpsr_read_en) bus.cpsr_read_value <= cpsr;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ($countones({bus.write_en, bus.read_en, bus.mode_read_en,
                                 bus.cpsr_read_en, bus.cpsr_write_en}) > 1))
            onehot_viol++;
        if (bus.write_en) begin
            chk("wr_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_kind", 64'd0, 64'(e.is_cpsr));
                chk("wr_reg", 64'(bus.write_reg), 64'(e.rg));
                chk("wr_val", 64'(bus.write_value), 64'(e.val));
                chk("wr_restore", 64'(bus.write_restore_from_SPSR), 64'(e.rest));
            end
            regs[bus.write_reg] = bus.write_value;
        end
        if (bus.cpsr_write_en) begin
            chk("cpsr_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("cpsr_kind", 64'd1, 64'(e.is_cpsr));
                chk("cpsr_val", 64'(bus.cpsr_write_value), 64'(e.val));
            end
            cpsr = bus.cpsr_write_value;
        end
    end

    task automatic push_wr(input logic [3:0] rg, input logic [31:0] val, input logic rest);
        exp_t e;
        e.is_cpsr = 1'b0; e.rg = rg; e.val = val; e.rest = rest;
        sb.push_back(e);
    endtask

    task automatic push_flags(input logic [3:0] nzcv);
        exp_t e;
        e.is_cpsr = 1'b1; e.rg = 4'd0; e.val = {nzcv, cpsr[27:0]}; e.rest = 1'b0;
        sb.push_back(e);
    endtask

    task automatic start_op(input logic imm, input logic [3:0] opc, input logic s,
                            input logic [3:0] rn, input logic [3:0] rd,
                            input logic [11:0] op2, input int hold);
        @(negedge clk);
        bus.en = 1'b1; bus.immediate = imm; bus.opcode = opc; bus.s = s;
        bus.rn = rn; bus.rd = rd; bus.operand2 = op2;
        repeat (hold) @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic imm, input logic [3:0] opc,
                          input logic s, input logic [3:0] rn, input logic [3:0] rd,
                          input logic [11:0] op2, input int hold);
        start_op(imm, opc, s, rn, rd, op2, hold);
        repeat (16) @(negedge clk);
        chk({tag, "_pending"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        n_vec = 0; n_err = 0; onehot_viol = 0;
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        mode = 5'b10000;
        cpsr = 32'h6000_0013;
        bus.en = 1'b0; bus.immediate = 1'b0; bus.opcode = 4'd0; bus.s = 1'b0;
        bus.rn = 4'd0; bus.rd = 4'd0; bus.operand2 = 12'd0;
        bus.read_value = 32'd0; bus.mode_read_value = 32'd0; bus.cpsr_read_value = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_write_en", 64'(bus.write_en), 64'd0);
        chk("rst_cpsr_write_en", 64'(bus.cpsr_write_en), 64'd0);
        chk("rst_read_en", 64'(bus.read_en), 64'd0);
        chk("rst_write_value", 64'(bus.write_value), 64'd0);
        chk("rst_write_reg", 64'(bus.write_reg), 64'd0);
        chk("rst_read_reg", 64'(bus.read_reg), 64'd0);
        chk("rst_cpsr_write_value", 64'(bus.cpsr_write_value), 64'd0);
        rst = 1'b0;

        regs[1] = 32'd5; regs[2] = 32'd7;
        push_wr(4'd0, 32'd12, 1'b0);
        run_op("add", 1'b0, 4'h4, 1'b0, 4'd1, 4'd0, 12'h002, 1);

        regs[4] = 32'd20; regs[5] = 32'd3;
        push_wr(4'd3, 32'd17, 1'b0);
        run_op("sub", 1'b0, 4'h2, 1'b0, 4'd4, 4'd3, 12'h005, 1);

        regs[6] = 32'hFF00_FF00; regs[7] = 32'h0F0F_0F0F;
        push_wr(4'd8, 32'h0F00_0F00, 1'b0);
        run_op("and", 1'b0, 4'h0, 1'b0, 4'd6, 4'd8, 12'h007, 1);

        push_flags(4'b0010);
        run_op("cmp", 1'b0, 4'hA, 1'b0, 4'd4, 4'd0, 12'h005, 1);
        chk("cmp_cpsr", 64'(cpsr), 64'h2000_0013);

        push_wr(4'd9, 32'h0000_0123, 1'b0);
        run_op("mov", 1'b1, 4'hD, 1'b0, 4'd0, 4'd9, 12'h123, 1);

        // C=1 from CMP: 5 + 7 + 1
        push_wr(4'd0, 32'd13, 1'b0);
        run_op("adc", 1'b0, 4'h5, 1'b0, 4'd1, 4'd0, 12'h002, 1);

        regs[10] = 32'h7FFF_FFFF;
        push_wr(4'd11, 32'h8000_0000, 1'b0);
        push_flags(4'b1001);
        run_op("adds_ovf", 1'b1, 4'h4, 1'b1, 4'd10, 4'd11, 12'h001, 1);

        regs[12] = 32'd3;
        push_wr(4'd13, 32'd0, 1'b0);
        push_flags(4'b0110);
        run_op("subs_zero", 1'b1, 4'h2, 1'b1, 4'd12, 4'd13, 12'h003, 1);

        push_wr(4'd14, 32'd6, 1'b0);
        run_op("en_held", 1'b1, 4'h4, 1'b0, 4'd1, 4'd14, 12'h001, 2);

        // TEQ 5 ^ 5 with s=0: flags still written, C/V kept from CPSR (C=1, V=0)
        push_flags(4'b0110);
        run_op("teq", 1'b1, 4'h9, 1'b0, 4'd1, 4'd0, 12'h005, 1);

        mode = 5'b10011;
        push_wr(4'd15, 32'h40, 1'b1);
        run_op("movs_pc_svc", 1'b1, 4'hD, 1'b1, 4'd0, 4'd15, 12'h040, 1);

        mode = 5'b10000;
        push_wr(4'd15, 32'h40, 1'b0);
        push_flags({2'b00, cpsr[29:28]});
        run_op("movs_pc_usr", 1'b1, 4'hD, 1'b1, 4'd0, 4'd15, 12'h040, 1);

        // Abort during the Rn read: nothing may be written afterwards.
        @(negedge clk);
        bus.en = 1'b1; bus.immediate = 1'b0; bus.opcode = 4'h4; bus.s = 1'b1;
        bus.rn = 4'd1; bus.rd = 4'd2; bus.operand2 = 12'h002;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_op1", 64'(bus.read_en), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_read_en", 64'(bus.read_en), 64'd0);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        chk("abort_pending", 64'(sb.size()), 64'd0);
        chk("abort_r2_kept", 64'(regs[2]), 64'd7);

        chk("strobe_onehot", 64'(onehot_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
